// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART byte stream to checksummed command frame sequencer
//
// Hunts for SYNC_BYTE, then collects LEN, LEN payload bytes and CHK.
// CHK = (LEN + sum of payload) mod 256. A good frame is held until frame_ack.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   rx_byte        received byte from the UART receiver
//   rx_valid       byte valid; only its rising edge consumes a byte
//   frame_ack      consumer releases the held frame (ignored outside HOLD)
//   rd_addr        payload buffer read address
//   rd_data        payload byte at rd_addr, one cycle latency, 0 beyond frame_len
//   frame_valid    a complete, checked frame is held
//   frame_len      payload length of the held frame
//   busy           any state other than IDLE
//   err_*          single-cycle error pulses (length, checksum, timeout, overrun)
module uart_rx_frame_ctrl #(
    parameter int       MAX_PAYLOAD  = 16,
    parameter bit [7:0] SYNC_BYTE    = 8'hA5,
    parameter int       TIMEOUT_CLKS = 100000
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [7:0]                                    rx_byte,
    input  logic                                          rx_valid,
    input  logic                                          frame_ack,
    input  logic [((MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1)-1:0] rd_addr,
    output logic [7:0]                                    rd_data,
    output logic                                          frame_valid,
    output logic [7:0]                                    frame_len,
    output logic                                          busy,
    output logic                                          err_length,
    output logic                                          err_checksum,
    output logic                                          err_timeout,
    output logic                                          err_overrun
);

    localparam int       AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int       TW      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0]    MAX_LEN = 8'(MAX_PAYLOAD);
    localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CHECK,
        HOLD
    } state_t;

    state_t        state;
    logic          rx_valid_d;
    logic          byte_stb;
    logic [7:0]    len_q;
    logic [7:0]    sum_q;
    logic [7:0]    idx_q;
    logic [TW-1:0] to_cnt;
    logic [7:0]    payload_mem [MAX_PAYLOAD];

    // A level held for several cycles counts as one byte.
    assign byte_stb = rx_valid & ~rx_valid_d;

    // Both decode straight from the state register, so they change only on clk.
    assign frame_valid = (state == HOLD);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rx_valid_d   <= 1'b0;
            len_q        <= 8'h00;
            sum_q        <= 8'h00;
            idx_q        <= 8'h00;
            to_cnt       <= '0;
            frame_len    <= 8'h00;
            rd_data      <= 8'h00;
            err_length   <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            rx_valid_d   <= rx_valid;
            err_length   <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;

            rd_data <= ({{(8 - AW){1'b0}}, rd_addr} < frame_len) ? payload_mem[rd_addr] : 8'h00;

            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (byte_stb && rx_byte == SYNC_BYTE) begin
                        state <= LEN;
                    end
                end

                LEN, PAYLOAD, CHECK: begin
                    if (byte_stb) begin
                        // A byte in the terminal-count cycle wins over the timeout.
                        to_cnt <= '0;
                        case (state)
                            LEN: begin
                                if (rx_byte == 8'h00 || rx_byte > MAX_LEN) begin
                                    err_length <= 1'b1;
                                    state      <= IDLE;
                                end else begin
                                    len_q <= rx_byte;
                                    sum_q <= rx_byte;
                                    idx_q <= 8'h00;
                                    state <= PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                sum_q <= sum_q + rx_byte;
                                idx_q <= idx_q + 8'h01;
                                if (idx_q == len_q - 8'h01) begin
                                    state <= CHECK;
                                end
                            end
                            default: begin
                                if (rx_byte == sum_q) begin
                                    frame_len <= len_q;
                                    state     <= HOLD;
                                end else begin
                                    err_checksum <= 1'b1;
                                    state        <= IDLE;
                                end
                            end
                        endcase
                    end else if (to_cnt == TO_TERM) begin
                        err_timeout <= 1'b1;
                        to_cnt      <= '0;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    to_cnt <= '0;
                    // Bytes arriving while a frame is held are dropped.
                    if (byte_stb) begin
                        err_overrun <= 1'b1;
                    end
                    if (frame_ack) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Payload buffer is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && state == PAYLOAD && byte_stb) begin
            payload_mem[idx_q[AW-1:0]] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

    localparam int TO = 20;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       frame_ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic [7:0] frame_len;
    logic       busy;
    logic       err_length;
    logic       err_checksum;
    logic       err_timeout;
    logic       err_overrun;

    int n_checks = 0;
    int n_passed = 0;
    int n_len = 0, n_chk = 0, n_to = 0, n_ovr = 0;
    int b_len, b_chk, b_to, b_ovr;
    byte_q_t q;

    uart_rx_frame_ctrl #(
        .MAX_PAYLOAD (16),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .busy        (busy),
        .err_length  (err_length),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    // Counts cycles each pulse is high, sampled just before each rising edge.
    always @(posedge clk) begin
        if (err_length)   n_len++;
        if (err_checksum) n_chk++;
        if (err_timeout)  n_to++;
        if (err_overrun)  n_ovr++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic snap();
        b_len = n_len; b_chk = n_chk; b_to = n_to; b_ovr = n_ovr;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_seq(input byte_q_t s, input int hold);
        foreach (s[i]) send_byte(s[i], hold);
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        @(negedge clk);
        chk(tag, {8'h00, rd_data}, {8'h00, exp});
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_frame_valid", {15'd0, frame_valid}, 16'd0);
        chk("reset_busy",        {15'd0, busy},        16'd0);
        chk("reset_frame_len",   {8'd0, frame_len},    16'd0);
        chk("reset_rd_data",     {8'd0, rd_data},      16'd0);
        chk("reset_errs", {12'd0, err_length, err_checksum, err_timeout, err_overrun}, 16'd0);

        // Good frame, each byte held two cycles.
        q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_seq(q, 2);
        chk("good_frame_valid", {15'd0, frame_valid}, 16'd1);
        chk("good_frame_len",   {8'd0, frame_len},    16'd3);
        chk("good_busy",        {15'd0, busy},        16'd1);
        read_chk("good_rd0", 4'd0, 8'h11);
        read_chk("good_rd1", 4'd1, 8'h22);
        read_chk("good_rd2", 4'd2, 8'h33);
        read_chk("good_rd3", 4'd3, 8'h00);
        ack();
        chk("ack_frame_valid", {15'd0, frame_valid}, 16'd0);
        chk("ack_busy",        {15'd0, busy},        16'd0);

        // Bad checksum, then a good frame.
        snap();
        q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
        send_seq(q, 1);
        chk("badchk_pulses",      16'(n_chk - b_chk),   16'd1);
        chk("badchk_frame_valid", {15'd0, frame_valid}, 16'd0);
        chk("badchk_busy",        {15'd0, busy},        16'd0);
        q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
        send_seq(q, 1);
        chk("after_bad_valid", {15'd0, frame_valid}, 16'd1);
        chk("after_bad_len",   {8'd0, frame_len},    16'd2);

        // Overrun: three bytes while holding.
        snap();
        q = '{8'hAA, 8'hA5, 8'h00};
        send_seq(q, 1);
        chk("overrun_pulses", 16'(n_ovr - b_ovr),   16'd3);
        chk("overrun_valid",  {15'd0, frame_valid}, 16'd1);
        chk("overrun_len",    {8'd0, frame_len},    16'd2);
        read_chk("overrun_rd0", 4'd0, 8'h01);
        read_chk("overrun_rd1", 4'd1, 8'h02);

        // Byte and frame_ack in the same cycle.
        snap();
        rx_byte   = 8'h77;
        rx_valid  = 1'b1;
        frame_ack = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
        frame_ack = 1'b0;
        chk("collide_valid",   {15'd0, frame_valid}, 16'd0);
        chk("collide_busy",    {15'd0, busy},        16'd0);
        chk("collide_ovr_lvl", {15'd0, err_overrun}, 16'd1);
        @(negedge clk);
        chk("collide_ovr_cnt", 16'(n_ovr - b_ovr),   16'd1);

        // Length bounds.
        snap();
        q = '{8'hA5, 8'h00};
        send_seq(q, 1);
        chk("len_zero", 16'(n_len - b_len), 16'd1);
        chk("len_zero_busy", {15'd0, busy}, 16'd0);
        q = '{8'hA5, 8'h11};
        send_seq(q, 1);
        chk("len_17", 16'(n_len - b_len), 16'd2);
        q = '{8'hA5, 8'h10};
        for (int i = 1; i <= 16; i++) q.push_back(8'(i));
        q.push_back(8'h98);
        send_seq(q, 1);
        chk("len_max_valid", {15'd0, frame_valid}, 16'd1);
        chk("len_max_len",   {8'd0, frame_len},    16'd16);
        read_chk("len_max_rd15", 4'd15, 8'h10);
        read_chk("len_max_rd0",  4'd0,  8'h01);
        ack();

        // Timeout: exactly TO silent cycles after the last byte.
        snap();
        q = '{8'hA5, 8'h02, 8'h11};
        send_seq(q, 1);
        repeat (TO - 2) @(negedge clk);
        chk("to_not_yet_busy", {15'd0, busy},        16'd1);
        chk("to_not_yet_lvl",  {15'd0, err_timeout}, 16'd0);
        @(negedge clk);
        chk("to_fire_lvl",  {15'd0, err_timeout}, 16'd1);
        chk("to_fire_busy", {15'd0, busy},        16'd0);
        @(negedge clk);
        chk("to_one_cycle", {15'd0, err_timeout}, 16'd0);
        chk("to_count",     16'(n_to - b_to),     16'd1);

        // Byte lands in the terminal-count cycle: no timeout.
        snap();
        q = '{8'hA5, 8'h02, 8'h11};
        send_seq(q, 1);
        repeat (TO - 2) @(negedge clk);
        rx_byte  = 8'h22;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("to_edge_count", 16'(n_to - b_to), 16'd0);
        chk("to_edge_busy",  {15'd0, busy},    16'd1);
        send_byte(8'h35, 1);
        chk("to_edge_valid", {15'd0, frame_valid}, 16'd1);
        read_chk("to_edge_rd1", 4'd1, 8'h22);
        ack();

        // Reset in the middle of a payload.
        snap();
        q = '{8'hA5, 8'h04, 8'h11};
        send_seq(q, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", {15'd0, busy}, 16'd0);
        chk("rst_mid_errs", {12'd0, err_length, err_checksum, err_timeout, err_overrun}, 16'd0);
        q = '{8'h11, 8'h22};
        send_seq(q, 1);
        chk("rst_garbage_busy", {15'd0, busy}, 16'd0);
        chk("rst_no_err", 16'(n_len - b_len + n_chk - b_chk + n_to - b_to + n_ovr - b_ovr), 16'd0);
        q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
        send_seq(q, 1);
        chk("rst_after_valid", {15'd0, frame_valid}, 16'd1);
        chk("rst_after_len",   {8'd0, frame_len},    16'd1);
        read_chk("rst_after_rd0", 4'd0, 8'h5A);
        ack();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sits directly behind the UART receiver and sequences its byte stream into length-prefixed, checksummed command frames.
- Hunts for a sync byte, then collects length, payload and checksum, and stores the payload in an internal buffer.
- Presents a complete frame to the command consumer and holds it until acknowledged.
- Reports framing errors (bad length, bad checksum, inter-byte timeout, overrun) as single-cycle pulses.

Parameters:
- MAX_PAYLOAD, 16, maximum payload bytes per frame (1..255).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 100000, maximum clocks allowed between consecutive bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_byte  in  8  received byte from UART receiver
- rx_valid  in  1  byte-valid from UART receiver; may stay high for several consecutive cycles per byte
- frame_ack  in  1  consumer releases the held frame
- rd_addr  in  $clog2(MAX_PAYLOAD)  payload buffer read address
- rd_data  out  8  payload byte at rd_addr, registered
- frame_valid  out  1  level; a complete, checked frame is held
- frame_len  out  8  payload length of held frame
- busy  out  1  high in any state other than IDLE
- err_length  out  1  one-cycle error pulse
- err_checksum  out  1  one-cycle error pulse
- err_timeout  out  1  one-cycle error pulse
- err_overrun  out  1  one-cycle error pulse

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; all outputs 0; rx_valid_d=0; timeout counter=0; running sum=0; payload index=0. Buffer contents are not cleared. Reset mid-frame abandons the frame with no error pulse.
- Byte strobe: byte_stb = rx_valid & ~rx_valid_d, with rx_valid_d registered every cycle. Exactly one byte is consumed per rising edge of rx_valid, so a level held N cycles counts as one byte.
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK. CHK must equal (LEN + sum of payload) mod 256, using 8-bit wrap-around addition.
- IDLE: on byte_stb with rx_byte==SYNC_BYTE go to LEN. Any other byte is silently ignored.
- LEN: on byte_stb:
  - if rx_byte==0 or rx_byte>MAX_PAYLOAD: pulse err_length, go to IDLE.
  - else latch the length, sum=rx_byte, index=0, go to PAYLOAD.
- PAYLOAD: on byte_stb: buf[index]=rx_byte, sum+=rx_byte, index+=1. When index reaches LEN-1 (i.e. on the last payload byte) go to CHECK.
- CHECK: on byte_stb:
  - if rx_byte==sum: frame_len=LEN, go to HOLD.
  - else pulse err_checksum, go to IDLE.
- HOLD: frame_valid=1; buffer and frame_len are frozen.
  - Each byte_stb is discarded and pulses err_overrun; state stays HOLD.
  - frame_ack=1 → IDLE next cycle; frame_valid=0 from that edge.
  - If frame_ack and byte_stb occur in the same cycle, the byte is discarded with err_overrun, then the block returns to IDLE.
- frame_ack outside HOLD is ignored.
- Latency: frame_valid rises on the clock edge that samples the CHK byte_stb, visible the cycle after. Error pulses have the same timing and last exactly one cycle.
- Timeout: the counter clears on every byte_stb and in IDLE/HOLD, and increments in LEN/PAYLOAD/CHECK. When it reaches TIMEOUT_CLKS-1 with no byte_stb: pulse err_timeout, go to IDLE. A byte_stb in the terminal-count cycle wins; no timeout is reported.
- A SYNC_BYTE value received in LEN/PAYLOAD/CHECK is treated as ordinary data, with no resync.
- Read port: rd_data <= (rd_addr < frame_len) ? buf[rd_addr] : 8'h00 every cycle, giving 1-cycle read latency. It is valid in any state, but only meaningful while frame_valid=1.
- busy=1 in LEN, PAYLOAD, CHECK and HOLD.
- Single clock domain; rx_byte/rx_valid are already synchronous to clk.

Test Plan:
- Good frame: bytes A5 03 11 22 33 69, each with rx_valid held 2 cycles → frame_valid=1, frame_len=3; rd_addr 0/1/2 return 11/22/33 one cycle later; rd_addr 3 returns 00; frame_ack → frame_valid=0, busy=0 next cycle.
- Bad checksum: A5 03 11 22 33 6A → single err_checksum pulse, frame_valid stays 0, state IDLE. A following good frame is accepted.
- Length bounds: A5 00 → err_length. A5 11 with MAX_PAYLOAD=16 → err_length. A5 10 plus 16 payload bytes plus correct CHK → frame_len=16.
- Timeout: A5 02 11, then silence for TIMEOUT_CLKS clocks → one err_timeout pulse, busy=0. A byte arriving at exactly TIMEOUT_CLKS-1 idle cycles → no timeout.
- Overrun/ack collision: in HOLD send 3 bytes → 3 err_overrun pulses with buffer unchanged. A byte with a simultaneous frame_ack → err_overrun plus return to IDLE.
- Reset mid-frame: rst during PAYLOAD → next cycle busy=0, all error pulses 0; garbage bytes 11 22 are ignored, then a good frame is accepted.
